// File: rtl/range_count_pkg.sv
// Shared types and defaults for the range_count_ctrl sequencer.
// Optional down-counting is enabled with RANGE_COUNT_CTRL_DOWN_EN.
package range_count_pkg;

  localparam int W_DEF    = 4;
  localparam int LAPW_DEF = 8;
  localparam int LAPS_INF = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Lap register value after a completed lap; continuous mode stays at LAPS_INF.
  function automatic logic [31:0] laps_after_wrap(input logic [31:0] laps_left);
    if (laps_left == 32'(LAPS_INF)) begin
      laps_after_wrap = laps_left;
    end else begin
      laps_after_wrap = laps_left - 32'd1;
    end
  endfunction

endpackage

// File: rtl/range_counter.sv
// Loadable W-bit wrap-around count register with end-of-lap detection.
// Direction input exists only when RANGE_COUNT_CTRL_DOWN_EN is defined.
module range_counter
  import range_count_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
`ifdef RANGE_COUNT_CTRL_DOWN_EN
  input  logic         dir,
`endif
  output logic [W-1:0] count,
  output logic         at_end
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         down_s;

`ifdef RANGE_COUNT_CTRL_DOWN_EN
  assign down_s = dir;
`else
  assign down_s = 1'b0;
`endif

  assign at_end = down_s ? (count_q == lo) : (count_q == hi);
  assign count  = count_q;

  // Next count: load wins, otherwise step or wrap to the lap start.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (at_end) begin
        count_d = down_s ? hi : lo;
      end else if (down_s) begin
        count_d = count_q - W'(1);
      end else begin
        count_d = count_q + W'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/range_count_ctrl.sv
// Run sequencer: accepts lo/hi/laps commands, drives range_counter, flags laps and run end.
// Define RANGE_COUNT_CTRL_DOWN_EN to add the cmd_down port for down-counting laps.
module range_count_ctrl
  import range_count_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int LAPW = LAPW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [W-1:0]    cmd_lo,
  input  logic [W-1:0]    cmd_hi,
  input  logic [LAPW-1:0] cmd_laps,
`ifdef RANGE_COUNT_CTRL_DOWN_EN
  input  logic            cmd_down,
`endif
  input  logic            abort,
  output logic            busy,
  output logic [W-1:0]    count,
  output logic            count_valid,
  output logic            lap_done,
  output logic            done,
  output logic            err
);

  state_e          state_q;
  logic [W-1:0]    lo_q;
  logic [W-1:0]    hi_q;
  logic [LAPW-1:0] laps_left_q;
  logic            cmd_ready_q;
  logic            busy_q;
  logic            lap_done_q;
  logic            done_q;
  logic            err_q;

  logic            down_s;
  logic            cmd_down_s;
  logic            at_end_s;
  logic            accept_s;
  logic            reject_s;
  logic            last_lap_s;
  logic            step_en_s;
  logic [W-1:0]    load_val_s;

`ifdef RANGE_COUNT_CTRL_DOWN_EN
  logic            down_q;
  assign down_s     = down_q;
  assign cmd_down_s = cmd_down;
`else
  assign down_s     = 1'b0;
  assign cmd_down_s = 1'b0;
`endif

  // Handshake decode and counter step enable; the final lap end holds the count.
  always_comb begin
    accept_s   = 1'b0;
    reject_s   = 1'b0;
    step_en_s  = 1'b0;
    last_lap_s = (laps_left_q == LAPW'(1));
    load_val_s = cmd_down_s ? cmd_hi : cmd_lo;
    if (state_q == ST_IDLE && cmd_valid) begin
      accept_s = (cmd_lo <= cmd_hi);
      reject_s = (cmd_lo > cmd_hi);
    end else begin
      accept_s = 1'b0;
      reject_s = 1'b0;
    end
    if (state_q == ST_RUN && !abort) begin
      step_en_s = !(at_end_s && last_lap_s);
    end else begin
      step_en_s = 1'b0;
    end
  end

  range_counter #(
    .W(W)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept_s),
    .load_val (load_val_s),
    .en       (step_en_s),
    .lo       (lo_q),
    .hi       (hi_q),
`ifdef RANGE_COUNT_CTRL_DOWN_EN
    .dir      (down_q),
`endif
    .count    (count),
    .at_end   (at_end_s)
  );

  // Sequencer FSM with registered status and pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      laps_left_q <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      lap_done_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef RANGE_COUNT_CTRL_DOWN_EN
      down_q      <= 1'b0;
`endif
    end else begin
      lap_done_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            lo_q        <= cmd_lo;
            hi_q        <= cmd_hi;
            laps_left_q <= cmd_laps;
`ifdef RANGE_COUNT_CTRL_DOWN_EN
            down_q      <= cmd_down;
`endif
            state_q     <= ST_RUN;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end else if (reject_s) begin
            err_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // Abort outranks both the wrap and the finish.
          if (abort) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else if (at_end_s) begin
            lap_done_q <= 1'b1;
            if (last_lap_s) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              laps_left_q <= LAPW'(laps_after_wrap(32'(laps_left_q)));
            end
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign count_valid = busy_q;
  assign lap_done    = lap_done_q;
  assign done        = done_q;
  assign err         = err_q;

  logic unused_s;
  assign unused_s = down_s;

endmodule

// File: tb/tb_range_count_ctrl.sv
// Self-checking bench for range_count_ctrl against a closed-form run model.
module tb_range_count_ctrl;

  localparam int W    = 4;
  localparam int LAPW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [W-1:0]    cmd_lo;
  logic [W-1:0]    cmd_hi;
  logic [LAPW-1:0] cmd_laps;
  logic            abort;
  logic            busy;
  logic [W-1:0]    count;
  logic            count_valid;
  logic            lap_done;
  logic            done;
  logic            err;
`ifdef RANGE_COUNT_CTRL_DOWN_EN
  logic            cmd_down;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_count;

  always #5 clk = ~clk;

  range_count_ctrl #(.W(W), .LAPW(LAPW)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_lo      (cmd_lo),
    .cmd_hi      (cmd_hi),
    .cmd_laps    (cmd_laps),
`ifdef RANGE_COUNT_CTRL_DOWN_EN
    .cmd_down    (cmd_down),
`endif
    .abort       (abort),
    .busy        (busy),
    .count       (count),
    .count_valid (count_valid),
    .lap_done    (lap_done),
    .done        (done),
    .err         (err)
  );

  // Issues one command from IDLE (at a negedge) and checks every cycle until IDLE again.
  // Cycle k = k-th cycle after the accepting edge; abort_at>0 raises abort during cycle abort_at.
  task automatic drive_run(input int lo, input int hi, input int laps, input int abort_at,
                           input bit noise, input bit dn, input string tag);
    int len, run_cycles, last_k, pos;
    logic [W-1:0] e_cnt;
    logic [5:0]   e_flags, a_flags;
    logic         e_busy, e_lap, e_done, e_ready;
    len        = hi - lo + 1;
    run_cycles = (laps == 0) ? 32'h3fff_ffff : laps * len;
    last_k     = (abort_at > 0) ? abort_at + 1 : run_cycles + 2;
    cmd_valid  = 1'b1;
    cmd_lo     = W'(lo);
    cmd_hi     = W'(hi);
    cmd_laps   = LAPW'(laps);
`ifdef RANGE_COUNT_CTRL_DOWN_EN
    cmd_down   = dn;
`endif
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_cmd got %b want 1", tag, cmd_ready);
    end
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      if (abort_at > 0 && k == abort_at + 1) begin
        e_cnt = last_count; e_busy = 1'b0; e_lap = 1'b0; e_done = 1'b0; e_ready = 1'b1;
      end else if (k <= run_cycles) begin
        pos    = (k - 1) % len;
        e_cnt  = dn ? W'(hi - pos) : W'(lo + pos);
        e_busy = 1'b1; e_done = 1'b0; e_ready = 1'b0;
        e_lap  = (k >= 2) && ((k - 1) % len == 0);
      end else if (k == run_cycles + 1) begin
        e_cnt = dn ? W'(lo) : W'(hi); e_busy = 1'b0; e_lap = 1'b1; e_done = 1'b1; e_ready = 1'b0;
      end else begin
        e_cnt = dn ? W'(lo) : W'(hi); e_busy = 1'b0; e_lap = 1'b0; e_done = 1'b0; e_ready = 1'b1;
      end
      e_flags = {e_busy, e_busy, e_lap, e_done, e_ready, 1'b0};
      a_flags = {busy, count_valid, lap_done, done, cmd_ready, err};
      checks++;
      if (count !== e_cnt) begin
        errors++;
        $display("FAIL %s count cycle %0d got %0d want %0d", tag, k, count, e_cnt);
      end
      checks++;
      if (a_flags !== e_flags) begin
        errors++;
        $display("FAIL %s flags(busy,cv,lap,done,rdy,err) cycle %0d got %b want %b",
                 tag, k, a_flags, e_flags);
      end
      last_count = e_cnt;
      abort = (k == abort_at) || (noise && abort_at == 0 && k == run_cycles + 1);
      cmd_valid = noise && (k < last_k);
      if (noise) begin
        cmd_lo   = W'($urandom_range(0, 15));
        cmd_hi   = W'($urandom_range(0, 15));
        cmd_laps = LAPW'($urandom_range(0, 5));
      end
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({count, busy, count_valid, lap_done, done, cmd_ready, err} !== {W'(0), 6'b000010}) begin
      errors++;
      $display("FAIL reset_values got count=%0d flags=%b want count=0 flags=000010",
               count, {busy, count_valid, lap_done, done, cmd_ready, err});
    end
    reset = 1'b0;
    last_count = '0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b busy=%b want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_err(input int lo, input int hi);
    cmd_valid = 1'b1; cmd_lo = W'(lo); cmd_hi = W'(hi); cmd_laps = LAPW'(2);
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({busy, count_valid, lap_done, done, cmd_ready, err} !== 6'b000011 || count !== last_count) begin
      errors++;
      $display("FAIL err_pulse lo=%0d hi=%0d got flags=%b count=%0d want 000011 count=%0d",
               lo, hi, {busy, count_valid, lap_done, done, cmd_ready, err}, count, last_count);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_one_cycle got err=%b rdy=%b busy=%b want 0 1 0", err, cmd_ready, busy);
    end
  endtask

  task automatic test_mid_reset();
    cmd_valid = 1'b1; cmd_lo = W'(2); cmd_hi = W'(9); cmd_laps = LAPW'(2);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (count !== W'(5) || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_prerun got count=%0d busy=%b want 5 1", count, busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (count !== W'(0) || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async got count=%0d rdy=%b busy=%b done=%b want 0 1 0 0",
               count, cmd_ready, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    last_count = '0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || lap_done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_after got done=%b lap=%b rdy=%b want 0 0 1", done, lap_done, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    drive_run(1, 2, 2, 0, 1'b0, 1'b0, "b2b_first");
    drive_run(10, 11, 1, 0, 1'b0, 1'b0, "b2b_second");
  endtask

  task automatic test_random();
    int a, b, lo, hi, laps, ab, len;
    bit dn;
    for (int i = 0; i < 25; i++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      if (a != b && $urandom_range(0, 4) == 0) begin
        test_err((a > b) ? a : b, (a > b) ? b : a);
      end else begin
        lo   = (a < b) ? a : b;
        hi   = (a < b) ? b : a;
        len  = hi - lo + 1;
        laps = $urandom_range(0, 3);
        if (laps == 0) ab = $urandom_range(1, 40);
        else if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, laps * len);
        else ab = 0;
        dn = 1'b0;
`ifdef RANGE_COUNT_CTRL_DOWN_EN
        dn = 1'($urandom_range(0, 1));
`endif
        drive_run(lo, hi, laps, ab, 1'($urandom_range(0, 1)), dn, "random");
      end
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_lo = '0; cmd_hi = '0; cmd_laps = '0; abort = 1'b0;
`ifdef RANGE_COUNT_CTRL_DOWN_EN
    cmd_down = 1'b0;
`endif
    test_reset();
    drive_run(3, 12, 1, 0, 1'b0, 1'b0, "single_lap");
    drive_run(3, 5, 3, 0, 1'b0, 1'b0, "multi_lap");
    test_err(9, 4);
    drive_run(0, 15, 0, 104, 1'b0, 1'b0, "continuous_abort");
    drive_run(6, 6, 4, 0, 1'b1, 1'b0, "equal_bounds_ignore_cmd");
    test_back_to_back();
    test_mid_reset();
`ifdef RANGE_COUNT_CTRL_DOWN_EN
    drive_run(3, 12, 2, 0, 1'b0, 1'b1, "down_count");
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
